// File: rtl/sme_pkg.sv
// Shared character codes, FSM state type and width helpers for the scan engine.
package sme_pkg;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_HAT    = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        LD_STR,
        LD_PAT,
        SCAN
    } sme_state_t;

    // Bits needed to address n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational check of one candidate start position: window[0] is the character
// before the candidate, window[1..] the candidate and what follows it.
module sme_window_cmp
    import sme_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int PL_W    = len_width(PAT_MAX)
) (
    input  logic [PAT_MAX+1:0][CHAR_W-1:0] window,
    input  logic [PAT_MAX-1:0][CHAR_W-1:0] pattern,
    input  logic [PL_W-1:0]                eff_len,
    input  logic                           anch_s,
    input  logic                           anch_e,
    output logic                           hit
);
    localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CH_SPACE);
    localparam logic [CHAR_W-1:0] DOT   = CHAR_W'(CH_DOT);

    logic [PAT_MAX*CHAR_W-1:0] eff_flat;
    logic [CHAR_W-1:0]         pc;
    logic [CHAR_W-1:0]         end_char;
    logic                      chars_ok;

    // Dropping a leading '^' leaves the effective characters starting at slot 0.
    always_comb begin
        eff_flat = anch_s ? (pattern >> CHAR_W) : pattern;
        chars_ok = 1'b1;
        end_char = window[1];
        pc       = '0;
        for (int k = 0; k < PAT_MAX; k++) begin
            pc = eff_flat[k*CHAR_W +: CHAR_W];
            if (PL_W'(k) < eff_len && pc != DOT && pc != window[k+1]) begin
                chars_ok = 1'b0;
            end
        end
        for (int j = 0; j <= PAT_MAX; j++) begin
            if (PL_W'(j) == eff_len) begin
                end_char = window[j+1];
            end
        end
        hit = chars_ok && (!anch_s || window[0] == SPACE) && (!anch_e || end_char == SPACE);
    end

endmodule

// File: rtl/sme_scan_engine.sv
// String-match engine top: string/pattern buffers, load/scan FSM and result registers.
module sme_scan_engine
    import sme_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = idx_width(STR_MAX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index
);
    localparam int LEN_W = IDX_W + 1;
    localparam int SUM_W = LEN_W + 1;
    localparam int PL_W  = len_width(PAT_MAX);
    localparam int PI_W  = idx_width(PAT_MAX);
    localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CH_SPACE);

    sme_state_t state, state_next;

    logic [CHAR_W-1:0]              str_buf [STR_MAX];
    logic [PAT_MAX-1:0][CHAR_W-1:0] pat_buf;
    logic [LEN_W-1:0]               str_len, p, str_waddr;
    logic [PL_W-1:0]                pat_len, eff_len, pat_waddr;
    logic                           str_we, pat_we, str_first, pat_first;
    logic                           res_hit, res_miss, anch_s, anch_e, hit, exhausted;
    logic [CHAR_W-1:0]              last_char;
    logic [PAT_MAX+1:0][CHAR_W-1:0] window;
    logic [SUM_W-1:0]               wpos;

    assign busy      = (state == SCAN);
    assign str_waddr = str_first ? '0 : str_len;
    assign pat_waddr = pat_first ? '0 : pat_len;

    always_comb begin
        last_char = pat_buf[0];
        for (int i = 0; i < PAT_MAX; i++) begin
            if (PL_W'(i + 1) == pat_len) begin
                last_char = pat_buf[i];
            end
        end
    end

    assign anch_s    = (pat_buf[0] == CHAR_W'(CH_HAT));
    assign anch_e    = (last_char == CHAR_W'(CH_DOLLAR));
    assign eff_len   = pat_len - PL_W'(anch_s) - PL_W'(anch_e);
    assign exhausted = (SUM_W'(p) + SUM_W'(eff_len)) > SUM_W'(str_len);

    // Positions before the string start or past its end read as spaces, which lets the
    // comparator treat both anchors as plain "neighbour is a space" tests.
    always_comb begin
        window = '0;
        wpos   = '0;
        for (int j = 0; j < PAT_MAX + 2; j++) begin
            wpos = SUM_W'(p) + SUM_W'(j);
            if (wpos == '0 || wpos > SUM_W'(str_len)) begin
                window[j] = SPACE;
            end else begin
                window[j] = str_buf[IDX_W'(wpos - SUM_W'(1))];
            end
        end
    end

    sme_window_cmp #(
        .CHAR_W  (CHAR_W),
        .PAT_MAX (PAT_MAX),
        .PL_W    (PL_W)
    ) u_cmp (
        .window  (window),
        .pattern (pat_buf),
        .eff_len (eff_len),
        .anch_s  (anch_s),
        .anch_e  (anch_e),
        .hit     (hit)
    );

    always_comb begin
        state_next = state;
        str_we     = 1'b0;
        pat_we     = 1'b0;
        str_first  = 1'b0;
        pat_first  = 1'b0;
        res_hit    = 1'b0;
        res_miss   = 1'b0;
        case (state)
            IDLE: begin
                if (isstring) begin
                    state_next = LD_STR;
                    str_we     = 1'b1;
                    str_first  = 1'b1;
                end else if (ispattern) begin
                    state_next = LD_PAT;
                    pat_we     = 1'b1;
                    pat_first  = 1'b1;
                end
            end
            LD_STR: begin
                if (ispattern) begin
                    state_next = LD_PAT;
                    pat_we     = 1'b1;
                    pat_first  = 1'b1;
                end else if (isstring) begin
                    str_we = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            LD_PAT: begin
                if (ispattern) begin
                    pat_we = 1'b1;
                end else begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (exhausted) begin
                    state_next = IDLE;
                    res_miss   = 1'b1;
                end else if (hit) begin
                    state_next = IDLE;
                    res_hit    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            str_len     <= '0;
            pat_len     <= '0;
            p           <= '0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
        end else begin
            state       <= state_next;
            valid       <= res_hit | res_miss;
            match       <= res_hit;
            match_index <= res_hit ? p[IDX_W-1:0] : '0;
            p           <= (state == SCAN) ? p + LEN_W'(1) : '0;
            if (str_we) begin
                str_len <= str_first ? LEN_W'(1) :
                           (str_len == LEN_W'(STR_MAX)) ? str_len : str_len + LEN_W'(1);
            end
            if (pat_we) begin
                pat_len <= pat_first ? PL_W'(1) :
                           (pat_len == PL_W'(PAT_MAX)) ? pat_len : pat_len + PL_W'(1);
            end
        end
    end

    // Buffers are only meaningful up to the stored lengths, so they carry no reset.
    always_ff @(posedge clk) begin
        if (str_we && str_waddr < LEN_W'(STR_MAX)) begin
            str_buf[str_waddr[IDX_W-1:0]] <= chardata;
        end
        if (pat_we && pat_waddr < PL_W'(PAT_MAX)) begin
            pat_buf[pat_waddr[PI_W-1:0]] <= chardata;
        end
    end

endmodule

// File: tb/tb_sme_scan_engine.sv
// Scoreboard bench for sme_scan_engine: directed cases plus randomized strings/patterns
// checked against a behavioural matcher.
module tb_sme_scan_engine;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int IDX_W   = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [7:0]       chardata = 8'h00;
    logic             isstring = 1'b0;
    logic             ispattern = 1'b0;
    logic             busy, valid, match;
    logic [IDX_W-1:0] match_index;

    typedef struct {
        bit m;
        int idx;
        int cyc;
    } exp_t;

    exp_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    string str_model = "";

    sme_scan_engine #(
        .CHAR_W  (8),
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX),
        .IDX_W   (IDX_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .busy        (busy),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: every valid pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", int'(valid), 0);
            end else begin
                e = exp_q.pop_front();
                check_output("match", int'(match), int'(e.m));
                check_output("match_index", int'(match_index), e.idx);
                check_output("result_cycle", cyc, e.cyc);
            end
        end
    end

    // Behavioural matcher: first start position satisfying the character and anchor rules.
    function automatic void ref_model(input string s, input string pat_in,
                                      output bit m, output int idx, output int lat);
        string pat;
        int    slen, plen, eff;
        bit    as, ae, ok;
        byte   c;
        pat  = (pat_in.len() > PAT_MAX) ? pat_in.substr(0, PAT_MAX - 1) : pat_in;
        slen = s.len();
        plen = pat.len();
        as   = (pat[0] == 8'h5E);
        ae   = (pat[plen-1] == 8'h24);
        eff  = plen - int'(as) - int'(ae);
        m    = 1'b0;
        idx  = 0;
        lat  = (eff > slen) ? 0 : slen - eff + 1;
        for (int p = 0; p + eff <= slen; p++) begin
            ok = 1'b1;
            for (int k = 0; k < eff; k++) begin
                c = pat[k + int'(as)];
                if (c != 8'h2E && c != s[p+k]) ok = 1'b0;
            end
            if (as && p != 0 && s[p-1] != 8'h20) ok = 1'b0;
            if (ae && p + eff != slen && s[p+eff] != 8'h20) ok = 1'b0;
            if (ok) begin
                m   = 1'b1;
                idx = p & ((1 << IDX_W) - 1);
                lat = p;
                return;
            end
        end
    endfunction

    task automatic send_string(input string s, input bit chain);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            isstring = 1'b1;
            chardata = s[i];
        end
        if (!chain) begin
            @(negedge clk);
            isstring = 1'b0;
        end
        str_model = (s.len() > STR_MAX) ? s.substr(0, STR_MAX - 1) : s;
    endtask

    task automatic start_pattern(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            @(negedge clk);
            isstring  = 1'b0;
            ispattern = 1'b1;
            chardata  = pat[i];
        end
        @(negedge clk);
        ispattern = 1'b0;
        chardata  = 8'h00;
    endtask

    task automatic wait_result();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_output("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input string pat, input bit m, input int idx, input int lat);
        exp_t e;
        start_pattern(pat);
        e.m   = m;
        e.idx = idx;
        e.cyc = cyc + 2 + lat;
        exp_q.push_back(e);
        wait_result();
    endtask

    task automatic apply_model(input string pat);
        bit m;
        int idx, lat;
        ref_model(str_model, pat, m, idx, lat);
        apply_stimulus(pat, m, idx, lat);
    endtask

    function automatic string fill_string(input int n, input int zpos);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, (i == zpos || i == zpos + 1) ? "z" : "a"};
        return s;
    endfunction

    function automatic string rand_string();
        string s, alph;
        int    n;
        alph = "ab c";
        s    = "";
        n    = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(0, 3);
            s = {s, alph.substr(k, k)};
        end
        return s;
    endfunction

    function automatic string rand_pattern();
        string s, alph;
        int    n;
        alph = "abc. ";
        s    = ($urandom_range(0, 2) == 0) ? "^" : "";
        n    = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(0, 4);
            s = {s, alph.substr(k, k)};
        end
        if ($urandom_range(0, 2) == 0) s = {s, "$"};
        if (s.len() == 0) s = "a";
        return s;
    endfunction

    initial begin
        string rs;
        int    np;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_valid", int'(valid), 0);
        check_output("reset_match", int'(match), 0);
        check_output("reset_index", int'(match_index), 0);
        reset_n = 1'b1;
        @(negedge clk);

        apply_stimulus("^$", 1'b1, 0, 0);
        apply_stimulus("a", 1'b0, 0, 0);

        send_string("hello world", 1'b0);
        apply_stimulus("wor", 1'b1, 6, 6);
        apply_stimulus("^wor", 1'b1, 6, 6);
        apply_stimulus("^orl", 1'b0, 0, 9);
        apply_stimulus("lo$", 1'b1, 3, 3);
        apply_stimulus("ld$", 1'b1, 9, 9);

        send_string("abcabc", 1'b1);
        apply_stimulus("c.b", 1'b1, 2, 2);
        apply_stimulus("b.a", 1'b1, 1, 1);
        apply_stimulus("abcd", 1'b0, 0, 3);

        send_string(fill_string(40, 35), 1'b0);
        apply_stimulus("zz", 1'b0, 0, 31);
        send_string(fill_string(40, 30), 1'b0);
        apply_stimulus("zz", 1'b1, 30, 30);

        send_string("hello world", 1'b0);
        start_pattern("wor");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_valid", int'(valid), 0);
        check_output("abort_match", int'(match), 0);
        check_output("abort_index", int'(match_index), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_output("abort_no_valid", int'(valid), 0);
        end
        send_string("abc def", 1'b0);
        apply_stimulus("^def", 1'b1, 4, 4);

        for (int it = 0; it < 40; it++) begin
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                rs = rand_string();
                send_string(rs, 1'($urandom_range(0, 1)));
            end
            np = $urandom_range(1, 3);
            for (int j = 0; j < np; j++) apply_model(rand_pattern());
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
